// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if
//   Instruction read bus between the fetch stage and instruction memory.
//
//   Handshake:
//     - master drives req_o/addr_o; a request is accepted in the cycle where
//       req_o & gnt_i are both high. While req_o is high and gnt_i is low the
//       master keeps req_o/addr_o stable (a redirect may withdraw it).
//     - slave returns read data in request order by pulsing rvalid_i with
//       rdata_i, at least one cycle after the matching gnt_i.
//
//   Signals:
//     req_o     master->slave  request valid
//     addr_o    master->slave  word-aligned read address
//     gnt_i     slave->master  request accepted this cycle
//     rvalid_i  slave->master  read data valid
//     rdata_i   slave->master  read data
// ---------------------------------------------------------------------------
interface if_fetch_if;
   logic        req_o;
   logic [31:0] addr_o;
   logic        gnt_i;
   logic        rvalid_i;
   logic [31:0] rdata_i;

   modport master (
      output req_o,
      output addr_o,
      input  gnt_i,
      input  rvalid_i,
      input  rdata_i
   );

   modport slave (
      input  req_o,
      input  addr_o,
      output gnt_i,
      output rvalid_i,
      output rdata_i
   );
endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//   Instruction fetch stage feeding the IF/ID pipeline register. Generates
//   the PC, issues reads on the req/gnt/rvalid bus, buffers returned words in
//   a small FIFO and presents one instruction (plus its address) per cycle.
//   Redirects from execute flush the buffer and discard responses that are
//   still in flight for the old path.
//
//   Ports:
//     clk, rst       clock, asynchronous active-high reset
//     hold_flag_i    pipeline hold code, 0 = advance
//     jump_flag_i    redirect request (highest priority)
//     jump_addr_i    redirect target (low two bits ignored)
//     bus            instruction read bus (master side)
//     inst_o         instruction to IF/ID (NOP when nothing valid)
//     inst_addr_o    address of inst_o
//     inst_valid_o   inst_o is a real fetched instruction
// ---------------------------------------------------------------------------
module if_fetch #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        hold_flag_i,
   input  logic              jump_flag_i,
   input  logic [31:0]       jump_addr_i,
   if_fetch_if.master        bus,
   output logic [31:0]       inst_o,
   output logic [31:0]       inst_addr_o,
   output logic              inst_valid_o
);

   localparam int          PW        = $clog2(FIFO_DEPTH);
   localparam int          CW        = PW + 1;
   localparam logic [31:0] INST_NOP  = 32'h0000_0001;
   localparam logic [2:0]  HOLD_NONE = 3'd0;
   localparam logic [CW:0] DEPTH_C   = (CW + 1)'(FIFO_DEPTH);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [31:0]   fetch_pc;      // next address to request
   logic [31:0]   resp_pc;       // address of the next response to be kept
   logic [CW-1:0] outstanding;   // granted requests without a response yet
   logic [CW-1:0] discard_cnt;   // in-flight responses belonging to an old path
   logic [CW-1:0] count;         // FIFO occupancy
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   logic [31:0]   fifo_inst [FIFO_DEPTH];
   logic [31:0]   fifo_addr [FIFO_DEPTH];

   // ---------------------------------------------------------------------
   // Control terms
   // ---------------------------------------------------------------------
   logic          fifo_empty;
   logic          advance;
   logic          pop;
   logic          resp;
   logic          drop;
   logic          push;
   logic          req;
   logic          issue;
   logic [CW:0]   credit;
   logic [31:0]   jump_target;

   logic [31:0]   fetch_pc_nxt;
   logic [31:0]   resp_pc_nxt;
   logic [CW-1:0] outstanding_nxt;
   logic [CW-1:0] discard_cnt_nxt;
   logic [CW-1:0] count_nxt;
   logic [PW-1:0] rd_ptr_nxt;
   logic [PW-1:0] wr_ptr_nxt;

   // Low address bits of a redirect are forced to zero and otherwise unused.
   logic          unused_jump_bits;
   assign unused_jump_bits = ^jump_addr_i[1:0];

   assign jump_target = {jump_addr_i[31:2], 2'b00};
   assign fifo_empty  = (count == '0);
   assign advance     = (hold_flag_i == HOLD_NONE) && !jump_flag_i;
   assign pop         = !fifo_empty && advance;

   // Responses only count while something is outstanding; anything else is
   // a spurious pulse (e.g. a late beat from before a reset) and is ignored.
   assign resp        = bus.rvalid_i && (outstanding != '0);
   assign drop        = resp && (discard_cnt != '0);
   assign push        = resp && (discard_cnt == '0) && !jump_flag_i;

   // Every granted request owns a FIFO slot until its word is popped, so
   // the FIFO can never overflow. A slot freed by this cycle's pop may be
   // reused right away, which is what keeps the stream at one per cycle.
   assign credit      = {1'b0, count} + {1'b0, outstanding}
                        - {{CW{1'b0}}, pop};
   assign req         = !rst && advance && (credit < DEPTH_C);
   assign issue       = req && bus.gnt_i;

   assign bus.req_o   = req;
   assign bus.addr_o  = fetch_pc;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      fetch_pc_nxt    = fetch_pc;
      resp_pc_nxt     = resp_pc;
      outstanding_nxt = outstanding + CW'(issue) - CW'(resp);
      discard_cnt_nxt = discard_cnt;
      count_nxt       = count + CW'(push) - CW'(pop);
      rd_ptr_nxt      = rd_ptr + PW'(pop);
      wr_ptr_nxt      = wr_ptr + PW'(push);

      if (issue) begin
         fetch_pc_nxt = fetch_pc + 32'd4;
      end
      if (push) begin
         resp_pc_nxt = resp_pc + 32'd4;
      end
      if (drop) begin
         discard_cnt_nxt = discard_cnt - 1'b1;
      end

      if (jump_flag_i) begin
         // Everything still in flight belongs to the old path. A response
         // landing this very cycle is already retired by the outstanding
         // decrement, so it is left out of the discard count.
         fetch_pc_nxt    = jump_target;
         resp_pc_nxt     = jump_target;
         discard_cnt_nxt = outstanding - CW'(resp);
         count_nxt       = '0;
         rd_ptr_nxt      = '0;
         wr_ptr_nxt      = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_ADDR;
         resp_pc     <= RESET_ADDR;
         outstanding <= '0;
         discard_cnt <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         fetch_pc    <= fetch_pc_nxt;
         resp_pc     <= resp_pc_nxt;
         outstanding <= outstanding_nxt;
         discard_cnt <= discard_cnt_nxt;
         count       <= count_nxt;
         rd_ptr      <= rd_ptr_nxt;
         wr_ptr      <= wr_ptr_nxt;
      end
   end

   // Buffer storage carries no reset: occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_inst[wr_ptr] <= bus.rdata_i;
         fifo_addr[wr_ptr] <= resp_pc;
      end
   end

   // ---------------------------------------------------------------------
   // IF/ID outputs: straight from the FIFO head. With nothing to offer (or
   // during a redirect) a NOP is presented at the address expected next.
   // ---------------------------------------------------------------------
   always_comb begin
      inst_o       = INST_NOP;
      inst_addr_o  = resp_pc;
      inst_valid_o = 1'b0;
      if (!fifo_empty && !jump_flag_i) begin
         inst_o       = fifo_inst[rd_ptr];
         inst_addr_o  = fifo_addr[rd_ptr];
         inst_valid_o = 1'b1;
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
//   Directed bench for if_fetch. dut drives a memory model whose grant and
//   response timing the sequence controls; dut_wrap runs free from a reset
//   address near the top of the address space. Memory returns
//   addr ^ 32'hA5A5_0000 for every read.
// ---------------------------------------------------------------------------
module tb_if_fetch;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  hold;
   logic        jump;
   logic [31:0] jaddr;
   logic        gnt;
   logic        resp_en;
   logic        spur;

   logic [31:0] inst, inst_addr;
   logic        inst_valid;
   logic [31:0] inst2, inst_addr2;
   logic        inst_valid2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   if_fetch_if bus1 ();
   if_fetch_if bus2 ();

   if_fetch #(.RESET_ADDR(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .hold_flag_i  (hold),
      .jump_flag_i  (jump),
      .jump_addr_i  (jaddr),
      .bus          (bus1),
      .inst_o       (inst),
      .inst_addr_o  (inst_addr),
      .inst_valid_o (inst_valid)
   );

   if_fetch #(.RESET_ADDR(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
      .clk          (clk),
      .rst          (rst),
      .hold_flag_i  (3'd0),
      .jump_flag_i  (1'b0),
      .jump_addr_i  (32'h0),
      .bus          (bus2),
      .inst_o       (inst2),
      .inst_addr_o  (inst_addr2),
      .inst_valid_o (inst_valid2)
   );

   // Memory for dut: accepted addresses queue up; with resp_en high the
   // oldest one is answered in the following cycle.
   logic [31:0] pend_q[$];
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   assign bus1.gnt_i    = gnt;
   assign bus1.rvalid_i = mem_rvalid | spur;
   assign bus1.rdata_i  = spur ? 32'hDEAD_BEEF : mem_rdata;

   always @(posedge clk) begin
      if (rst) begin
         pend_q.delete();
         mem_rvalid <= 1'b0;
         mem_rdata  <= 32'h0;
      end else begin
         if (bus1.req_o && bus1.gnt_i) pend_q.push_back(bus1.addr_o);
         mem_rvalid <= 1'b0;
         if (resp_en && pend_q.size() > 0) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= pend_q.pop_front() ^ KEY;
         end
      end
   end

   // Zero-wait memory for dut_wrap.
   logic        mem2_rvalid;
   logic [31:0] mem2_rdata;
   assign bus2.gnt_i    = 1'b1;
   assign bus2.rvalid_i = mem2_rvalid;
   assign bus2.rdata_i  = mem2_rdata;

   always @(posedge clk) begin
      if (rst) begin
         mem2_rvalid <= 1'b0;
         mem2_rdata  <= 32'h0;
      end else begin
         mem2_rvalid <= bus2.req_o && bus2.gnt_i;
         mem2_rdata  <= bus2.addr_o ^ KEY;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; hold = 3'd0; jump = 1'b0; jaddr = 32'h0;
      gnt = 1'b1; resp_en = 1'b1; spur = 1'b0;
      tick; tick;

      // reset state
      chk("rst_req",        bus1.req_o,  32'h0);
      chk("rst_inst",       inst,        32'h0000_0001);
      chk("rst_inst_addr",  inst_addr,   32'h0);
      chk("rst_valid",      inst_valid,  32'h0);
      chk("rst_req_w",      bus2.req_o,  32'h0);
      chk("rst_inst_addr_w",inst_addr2,  32'hFFFF_FFF8);

      // zero-wait streaming
      rst = 1'b0; #1;
      chk("c0_req",    bus1.req_o, 32'h1);
      chk("c0_addr",   bus1.addr_o, 32'h0);
      chk("c0_valid",  inst_valid, 32'h0);
      chk("c0_addr_w", bus2.addr_o, 32'hFFFF_FFF8);
      tick;
      chk("c1_valid",  inst_valid, 32'h0);
      chk("c1_addr",   bus1.addr_o, 32'h4);
      chk("c1_addr_w", bus2.addr_o, 32'hFFFF_FFFC);
      tick; gnt = 1'b0; #1;
      chk("c2_valid",       inst_valid, 32'h1);
      chk("c2_inst_addr",   inst_addr, 32'h0);
      chk("c2_inst",        inst, 32'hA5A5_0000);
      chk("c2_addr",        bus1.addr_o, 32'h8);
      chk("c2_addr_w",      bus2.addr_o, 32'h0);
      chk("c2_inst_addr_w", inst_addr2, 32'hFFFF_FFF8);
      chk("c2_inst_w",      inst2, 32'h5A5A_FFF8);

      // grant withheld: request held stable at 0x8
      tick;
      chk("c3_inst_addr",   inst_addr, 32'h4);
      chk("c3_inst",        inst, 32'hA5A5_0004);
      chk("c3_req",         bus1.req_o, 32'h1);
      chk("c3_addr",        bus1.addr_o, 32'h8);
      chk("c3_inst_addr_w", inst_addr2, 32'hFFFF_FFFC);
      tick;
      chk("c4_valid",       inst_valid, 32'h0);
      chk("c4_inst_addr",   inst_addr, 32'h8);
      chk("c4_addr",        bus1.addr_o, 32'h8);
      chk("c4_req",         bus1.req_o, 32'h1);
      chk("c4_inst_addr_w", inst_addr2, 32'h0);
      tick; gnt = 1'b1; #1;
      chk("c5_addr", bus1.addr_o, 32'h8);
      chk("c5_req",  bus1.req_o, 32'h1);
      tick;
      chk("c6_addr",  bus1.addr_o, 32'hC);
      chk("c6_valid", inst_valid, 32'h0);
      tick; resp_en = 1'b0; #1;
      chk("c7_valid",     inst_valid, 32'h1);
      chk("c7_inst_addr", inst_addr, 32'h8);
      chk("c7_inst",      inst, 32'hA5A5_0008);
      chk("c7_addr",      bus1.addr_o, 32'h10);
      tick;
      chk("c8_inst_addr", inst_addr, 32'hC);
      chk("c8_addr",      bus1.addr_o, 32'h14);
      chk("c8_req",       bus1.req_o, 32'h1);

      // hold for 4 cycles with two responses in flight
      tick; hold = 3'd2; resp_en = 1'b1; #1;
      chk("c9_req",       bus1.req_o, 32'h0);
      chk("c9_valid",     inst_valid, 32'h0);
      chk("c9_inst_addr", inst_addr, 32'h10);
      chk("c9_inst",      inst, 32'h0000_0001);
      tick;
      chk("c10_req",   bus1.req_o, 32'h0);
      chk("c10_valid", inst_valid, 32'h0);
      tick;
      chk("c11_valid",     inst_valid, 32'h1);
      chk("c11_inst_addr", inst_addr, 32'h10);
      chk("c11_inst",      inst, 32'hA5A5_0010);
      chk("c11_req",       bus1.req_o, 32'h0);
      tick;
      chk("c12_inst_addr", inst_addr, 32'h10);
      chk("c12_valid",     inst_valid, 32'h1);
      chk("c12_req",       bus1.req_o, 32'h0);
      tick; hold = 3'd0; #1;
      chk("c13_inst_addr", inst_addr, 32'h10);
      chk("c13_req",       bus1.req_o, 32'h1);
      chk("c13_addr",      bus1.addr_o, 32'h18);
      tick;
      chk("c14_inst_addr", inst_addr, 32'h14);
      chk("c14_inst",      inst, 32'hA5A5_0014);
      chk("c14_addr",      bus1.addr_o, 32'h1C);
      tick; resp_en = 1'b0; #1;
      chk("c15_inst_addr", inst_addr, 32'h18);
      chk("c15_addr",      bus1.addr_o, 32'h20);
      tick;
      chk("c16_inst_addr", inst_addr, 32'h1C);
      chk("c16_req",       bus1.req_o, 32'h1);
      chk("c16_addr",      bus1.addr_o, 32'h24);

      // jump with two stale requests outstanding
      tick; jump = 1'b1; jaddr = 32'h0000_0103; #1;
      chk("c17_valid", inst_valid, 32'h0);
      chk("c17_req",   bus1.req_o, 32'h0);
      chk("c17_inst",  inst, 32'h0000_0001);
      tick; jump = 1'b0; resp_en = 1'b1; #1;
      chk("c18_addr",      bus1.addr_o, 32'h100);
      chk("c18_req",       bus1.req_o, 32'h0);
      chk("c18_valid",     inst_valid, 32'h0);
      chk("c18_inst_addr", inst_addr, 32'h100);
      tick;
      chk("c19_req",   bus1.req_o, 32'h0);
      chk("c19_valid", inst_valid, 32'h0);
      tick;
      chk("c20_req",  bus1.req_o, 32'h1);
      chk("c20_addr", bus1.addr_o, 32'h100);
      tick;
      chk("c21_valid", inst_valid, 32'h0);
      chk("c21_addr",  bus1.addr_o, 32'h104);
      tick;
      chk("c22_valid",     inst_valid, 32'h1);
      chk("c22_inst_addr", inst_addr, 32'h100);
      chk("c22_inst",      inst, 32'hA5A5_0100);

      // jump coinciding with a response
      tick; jump = 1'b1; jaddr = 32'h0000_0200; #1;
      chk("c23_valid",     inst_valid, 32'h0);
      chk("c23_req",       bus1.req_o, 32'h0);
      chk("c23_inst_addr", inst_addr, 32'h108);
      tick; jump = 1'b0; #1;
      chk("c24_valid",     inst_valid, 32'h0);
      chk("c24_inst_addr", inst_addr, 32'h200);
      chk("c24_req",       bus1.req_o, 32'h1);
      chk("c24_addr",      bus1.addr_o, 32'h200);
      tick;
      chk("c25_valid", inst_valid, 32'h0);
      chk("c25_addr",  bus1.addr_o, 32'h204);
      tick;
      chk("c26_valid",     inst_valid, 32'h1);
      chk("c26_inst_addr", inst_addr, 32'h200);
      chk("c26_inst",      inst, 32'hA5A5_0200);

      // reset mid-stream, then a spurious response right after release
      rst = 1'b1; #1;
      chk("mrst_req",       bus1.req_o, 32'h0);
      chk("mrst_inst",      inst, 32'h0000_0001);
      chk("mrst_inst_addr", inst_addr, 32'h0);
      chk("mrst_valid",     inst_valid, 32'h0);
      tick; rst = 1'b0; spur = 1'b1; #1;
      chk("r0_req",  bus1.req_o, 32'h1);
      chk("r0_addr", bus1.addr_o, 32'h0);
      tick; spur = 1'b0; #1;
      chk("r1_valid", inst_valid, 32'h0);
      chk("r1_addr",  bus1.addr_o, 32'h4);
      tick;
      chk("r2_valid",     inst_valid, 32'h1);
      chk("r2_inst_addr", inst_addr, 32'h0);
      chk("r2_inst",      inst, 32'hA5A5_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
